fixed_point_mul_pipe: RTL and testbench

Pipelined signed fixed-point multiplier, the successor of the single-cycle fixed-point MUL.
- Adds configurable pipeline depth, a selectable rounding mode and overflow detection.
- Adds a valid/ready handshake on both sides, with full backpressure.
- Sits in datapaths (MAC chains, filters, neuron accumulators) where operands arrive as Q(WIDTH-FRAC_BITS).FRAC_BITS and downstream can stall.

---
 rtl/fixed_point_pkg.sv | 18 +
 rtl/fixed_point_rescale.sv | 45 ++++
 rtl/fixed_point_mul_pipe.sv | 79 +++++++
 tb/tb_fixed_point_mul_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared constants and helpers for the fixed-point arithmetic blocks
// (multiplier, and later the adder/MAC).
package fixed_point_pkg;

  localparam int unsigned ROUND_TRUNC   = 0;
  localparam int unsigned ROUND_HALF_UP = 1;

  // Largest representable two's-complement value of the given width, zero-extended to 64 bits.
  function automatic logic [63:0] fxp_max(int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Most negative representable value; its low 'width' bits are 100..0.
  function automatic logic [63:0] fxp_min(int unsigned width);
    return ~fxp_max(width);
  endfunction

endpackage

// File: rtl/fixed_point_rescale.sv
// Combinational rescale of a 2*WIDTH signed product to WIDTH bits: round, shift, overflow
// detect, and clamp when FIXED_POINT_MUL_SAT_EN is defined (wrap otherwise).
module fixed_point_rescale
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FRAC_BITS  = 3,
  parameter int unsigned ROUND_MODE = ROUND_TRUNC
) (
  input  logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   value,
  output logic               ovf
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [PW-1:0] RoundBias =
      (ROUND_MODE == ROUND_HALF_UP) ? (PW'(1) << (FRAC_BITS - 1)) : '0;

`ifdef FIXED_POINT_MUL_SAT_EN
  localparam logic [WIDTH-1:0] SatMax = WIDTH'(fxp_max(WIDTH));
  localparam logic [WIDTH-1:0] SatMin = WIDTH'(fxp_min(WIDTH));
`endif

  logic signed [PW-1:0] rounded;
  logic signed [PW-1:0] shifted;
  logic [WIDTH:0]       top_bits;

  always_comb begin
    rounded  = product + RoundBias;
    shifted  = rounded >>> FRAC_BITS;
    // Result fits in WIDTH bits only if every bit from the WIDTH sign bit upward agrees.
    top_bits = shifted[PW-1:WIDTH-1];
    ovf      = !((&top_bits) || !(|top_bits));
`ifdef FIXED_POINT_MUL_SAT_EN
    if (ovf) begin
      value = shifted[PW-1] ? SatMin : SatMax;
    end else begin
      value = shifted[WIDTH-1:0];
    end
`else
    value = shifted[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/fixed_point_mul_pipe.sv
// Pipelined signed fixed-point multiplier with valid/ready on both sides and full backpressure.
// Saturation on overflow is enabled by defining FIXED_POINT_MUL_SAT_EN.
module fixed_point_mul_pipe
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned FRAC_BITS   = 3,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned ROUND_MODE  = ROUND_TRUNC
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] VALUE_A_IN,
  input  logic [WIDTH-1:0] VALUE_B_IN,
  input  logic             VALID_IN,
  output logic             READY_OUT,
  output logic [WIDTH-1:0] VALUE_OUT,
  output logic             OVF_OUT,
  output logic             VALID_OUT,
  input  logic             READY_IN
);

  localparam int unsigned PW       = 2 * WIDTH;
  localparam int          NumProd  = PIPE_STAGES - 1;

  logic                   adv;
  logic [PW-1:0]          a_ext;
  logic [PW-1:0]          b_ext;
  logic [PW-1:0]          product;
  logic [PW-1:0]          prod_q [NumProd];
  logic [PIPE_STAGES-1:0] valid_q;
  logic [WIDTH-1:0]       value_q;
  logic [WIDTH-1:0]       value_d;
  logic                   ovf_q;
  logic                   ovf_d;

  // The low 2*WIDTH bits of the product of sign-extended operands are the exact signed product.
  assign a_ext   = {{WIDTH{VALUE_A_IN[WIDTH-1]}}, VALUE_A_IN};
  assign b_ext   = {{WIDTH{VALUE_B_IN[WIDTH-1]}}, VALUE_B_IN};
  assign product = a_ext * b_ext;

  // The whole pipe moves in lockstep; any stall at the output freezes every stage.
  assign adv       = !valid_q[PIPE_STAGES-1] || READY_IN;
  assign READY_OUT = adv;

  fixed_point_rescale #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .ROUND_MODE(ROUND_MODE)
  ) u_rescale (
    .product(prod_q[NumProd-1]),
    .value  (value_d),
    .ovf    (ovf_d)
  );

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      valid_q <= '0;
      for (int i = 0; i < NumProd; i++) begin
        prod_q[i] <= '0;
      end
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else if (adv) begin
      valid_q   <= {valid_q[PIPE_STAGES-2:0], VALID_IN};
      prod_q[0] <= product;
      for (int i = 1; i < NumProd; i++) begin
        prod_q[i] <= prod_q[i-1];
      end
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign VALUE_OUT = value_q;
  assign OVF_OUT   = ovf_q;
  assign VALID_OUT = valid_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_fixed_point_mul_pipe.sv
// Scoreboard bench for fixed_point_mul_pipe: a truncating and a rounding instance run in lockstep.
module tb_fixed_point_mul_pipe;
  import fixed_point_pkg::*;

  localparam int W = 8;
  localparam int F = 3;
  localparam int S = 2;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       vin  = 1'b0;
  logic       rin  = 1'b1;
  logic       rdy0, rdy1, vout0, vout1, ovf0, ovf1;
  logic [7:0] val0, val1;

  always #5 clk = ~clk;

  fixed_point_mul_pipe #(
    .WIDTH(W), .FRAC_BITS(F), .PIPE_STAGES(S), .ROUND_MODE(ROUND_TRUNC)
  ) u_trunc (
    .CLK(clk), .RSTN(rstn), .VALUE_A_IN(a_in), .VALUE_B_IN(b_in), .VALID_IN(vin),
    .READY_OUT(rdy0), .VALUE_OUT(val0), .OVF_OUT(ovf0), .VALID_OUT(vout0), .READY_IN(rin)
  );

  fixed_point_mul_pipe #(
    .WIDTH(W), .FRAC_BITS(F), .PIPE_STAGES(S), .ROUND_MODE(ROUND_HALF_UP)
  ) u_round (
    .CLK(clk), .RSTN(rstn), .VALUE_A_IN(a_in), .VALUE_B_IN(b_in), .VALID_IN(vin),
    .READY_OUT(rdy1), .VALUE_OUT(val1), .OVF_OUT(ovf1), .VALID_OUT(vout1), .READY_IN(rin)
  );

  typedef struct {
    logic [7:0] v0;
    logic       o0;
    logic [7:0] v1;
    logic       o1;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  int         out_log[$];
  int         n_vec    = 0;
  int         n_err    = 0;
  int         cyc      = 0;
  int         last_lat = -1;
  logic [7:0] last_v0  = '0;
  logic [7:0] last_v1  = '0;
  logic       last_o0  = 1'b0;
  logic       last_o1  = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] held0    = '0;
  logic       held_o0  = 1'b0;
  exp_t       e_push, e_pop;
  logic [8:0] m0, m1;

  int idx, stall_left, first_v;
  bit seen, acc;
  logic [7:0] va [4];
  logic [7:0] vb [4];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] model(logic [7:0] a, logic [7:0] b, bit rnd);
    int p, r;
    logic ovf;
    logic [7:0] v;
    p   = $signed(a) * $signed(b);
    r   = rnd ? ((p + (1 << (F - 1))) >>> F) : (p >>> F);
    ovf = (r > 127) || (r < -128);
    v   = r[7:0];
`ifdef FIXED_POINT_MUL_SAT_EN
    if (ovf) v = (r > 0) ? 8'h7F : 8'h80;
`endif
    return {ovf, v};
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: outputs and transfers sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      check_eq("ready_out", {31'd0, rdy0}, {31'd0, (!vout0 || rin)});
      check_eq("lockstep_valid", {31'd0, vout1}, {31'd0, vout0});
      check_eq("lockstep_ready", {31'd0, rdy1}, {31'd0, rdy0});
      if (stall_prev && vout0) begin
        check_eq("hold_value", {24'd0, val0}, {24'd0, held0});
        check_eq("hold_ovf", {31'd0, ovf0}, {31'd0, held_o0});
      end
      stall_prev = vout0 && !rin;
      held0      = val0;
      held_o0    = ovf0;
      if (vout0 && rin) begin
        if (sb.size() == 0) begin
          check_eq("spurious_valid", {31'd0, vout0}, 32'd0);
        end else begin
          e_pop = sb.pop_front();
          check_eq("trunc_value", {24'd0, val0}, {24'd0, e_pop.v0});
          check_eq("trunc_ovf", {31'd0, ovf0}, {31'd0, e_pop.o0});
          check_eq("round_value", {24'd0, val1}, {24'd0, e_pop.v1});
          check_eq("round_ovf", {31'd0, ovf1}, {31'd0, e_pop.o1});
          last_lat = cyc - e_pop.acc;
          out_log.push_back(cyc);
          last_v0 = val0;
          last_o0 = ovf0;
          last_v1 = val1;
          last_o1 = ovf1;
        end
      end
      if (vin && rdy0) begin
        m0 = model(a_in, b_in, 1'b0);
        m1 = model(a_in, b_in, 1'b1);
        e_push.v0  = m0[7:0];
        e_push.o0  = m0[8];
        e_push.v1  = m1[7:0];
        e_push.o1  = m1[8];
        e_push.acc = cyc;
        sb.push_back(e_push);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int guard = 0;
    a_in = a;
    b_in = b;
    vin  = 1'b1;
    #1;
    while (!rdy0 && guard < 50) begin
      tick();
      guard++;
    end
    if (!rdy0) check_eq("accept_timeout", {31'd0, rdy0}, 32'd1);
    tick();
    vin = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || vout0) && g < 60) begin
      tick();
      g++;
    end
    if (g >= 60) check_eq("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    va = '{8'h08, 8'h10, 8'hF0, 8'h7F};
    vb = '{8'h18, 8'hF8, 8'h0C, 8'h03};

    rstn = 1'b0;
    rin  = 1'b1;
    repeat (3) tick();
    check_eq("rst_valid", {31'd0, vout0}, 32'd0);
    check_eq("rst_value", {24'd0, val0}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf0}, 32'd0);
    rstn = 1'b1;
    #1;
    check_eq("rst_ready", {31'd0, rdy0}, 32'd1);

    // 1.5 * 2.0 = 3.0
    send(8'h0C, 8'h10);
    drain();
    check_eq("basic_value", {24'd0, last_v0}, 32'h18);
    check_eq("basic_ovf", {31'd0, last_o0}, 32'd0);
    check_eq("basic_latency", last_lat, 32'd2);

    // -0.125 * 0.5: floor gives -0.125, half-up gives 0
    send(8'hFF, 8'h04);
    drain();
    check_eq("round_trunc", {24'd0, last_v0}, 32'hFF);
    check_eq("round_halfup", {24'd0, last_v1}, 32'h00);

    send(8'h7F, 8'h7F);
    drain();
`ifdef FIXED_POINT_MUL_SAT_EN
    check_eq("ovf_pos_value", {24'd0, last_v0}, 32'h7F);
`else
    check_eq("ovf_pos_value", {24'd0, last_v0}, 32'hE0);
`endif
    check_eq("ovf_pos_flag", {31'd0, last_o0}, 32'd1);

    send(8'h80, 8'h80);
    drain();
`ifdef FIXED_POINT_MUL_SAT_EN
    check_eq("ovf_min_value", {24'd0, last_v0}, 32'h7F);
`else
    check_eq("ovf_min_value", {24'd0, last_v0}, 32'h00);
`endif
    check_eq("ovf_min_flag", {31'd0, last_o0}, 32'd1);

    // Backpressure: 4 back-to-back inputs, READY_IN low for 5 cycles from first VALID_OUT
    out_log.delete();
    seen       = 1'b0;
    stall_left = 0;
    idx        = 0;
    first_v    = 0;
    for (int c = 0; c < 40 && (idx < 4 || sb.size() != 0 || vout0); c++) begin
      if (!seen && vout0) begin
        seen       = 1'b1;
        stall_left = 5;
        first_v    = cyc;
      end
      rin = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      vin = (idx < 4);
      if (idx < 4) begin
        a_in = va[idx];
        b_in = vb[idx];
      end
      #1;
      if (!rin) check_eq("bp_ready_low", {31'd0, rdy0}, 32'd0);
      acc = vin && rdy0;
      tick();
      if (acc) idx++;
    end
    vin = 1'b0;
    rin = 1'b1;
    check_eq("bp_accepted", idx, 32'd4);
    check_eq("bp_delivered", out_log.size(), 32'd4);
    if (out_log.size() == 4) begin
      check_eq("bp_stall_len", out_log[0] - first_v, 32'd5);
      for (int i = 1; i < 4; i++) begin
        check_eq("bp_throughput", out_log[i] - out_log[i-1], 32'd1);
      end
    end

    // Reset with two operations in flight
    a_in = 8'h11;
    b_in = 8'h22;
    vin  = 1'b1;
    tick();
    a_in = 8'h33;
    b_in = 8'h44;
    tick();
    vin  = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (6) begin
      check_eq("post_rst_valid", {31'd0, vout0}, 32'd0);
      tick();
    end
    send(8'h18, 8'h08);
    drain();
    check_eq("post_rst_value", {24'd0, last_v0}, 32'h18);
    check_eq("post_rst_latency", last_lat, 32'd2);

    // Random traffic with random backpressure
    for (int i = 0; i < 80; i++) begin
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      vin  = 1'($urandom_range(0, 1));
      rin  = ($urandom_range(0, 3) != 0);
      tick();
    end
    vin = 1'b0;
    rin = 1'b1;
    drain();
    check_eq("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
